// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and width for the iterative multiply/divide unit
package mdu_pkg;
    localparam int MDU_W = 32;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} mdu_op_t;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;
    function automatic logic op_signed(mdu_op_t o);
        return o == OP_MULT || o == OP_DIV;
    endfunction
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step (used only when MDU_DIV_EN is defined)
module mdu_divstep #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);
    logic [W:0] sh, diff;
    always_comb begin
        sh = {rem, quo[W-1]};
        diff = sh - {1'b0, divisor};
        rem_next = diff[W] ? sh[W-1:0] : diff[W-1:0];
        quo_next = {quo[W-2:0], ~diff[W]};
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; divider compiled only with MDU_DIV_EN
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int W    = MDU_W,
    parameter int CNTW = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   mt_we,
    input  logic [W-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    mdu_state_t state;
    logic [CNTW-1:0] cnt;
    logic [2*W-1:0] acc, mul_next;
    logic [W-1:0] opb, abs_a, abs_b;
    logic [W:0] sum;
    logic sa, sb, is_div, sgn;
    // acc holds product (MUL) or {remainder, quotient} (DIV); opb is multiplicand or divisor
    always_comb begin
        sgn = op_signed(mdu_op_t'(op));
        abs_a = (sgn && a[W-1]) ? -a : a;
        abs_b = (sgn && b[W-1]) ? -b : b;
        sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : {W{1'b0}})};
        mul_next = {sum, acc[W-1:1]};
    end
    assign busy = state != IDLE;
`ifdef MDU_DIV_EN
    logic [W-1:0] dvd, rem_next, quo_next, rem_s, quo_s;
    mdu_divstep #(.W(W)) u_step (
        .rem(acc[2*W-1:W]),
        .quo(acc[W-1:0]),
        .divisor(opb),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );
    assign rem_s = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
    assign quo_s = (sa ^ sb) ? -acc[W-1:0] : acc[W-1:0];
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            opb <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            is_div <= 1'b0;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
`ifdef MDU_DIV_EN
            dvd <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sa <= sgn && a[W-1];
                    sb <= sgn && b[W-1];
                    is_div <= op[1];
                    cnt <= '0;
                    acc <= {{W{1'b0}}, (op[1] ? abs_a : abs_b)};
                    opb <= op[1] ? abs_b : abs_a;
`ifdef MDU_DIV_EN
                    dvd <= a;
                    state <= op[1] ? DIV : MUL;
`else
                    state <= op[1] ? FIX : MUL;
`endif
                end else begin
                    if (mt_we[1]) hi <= wd;
                    if (mt_we[0]) lo <= wd;
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(W - 1)) state <= FIX;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    acc <= {rem_next, quo_next};
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(W - 1)) state <= FIX;
                end
`endif
                FIX: begin
                    done <= 1'b1;
                    state <= IDLE;
`ifdef MDU_DIV_EN
                    // divide by zero reports the original dividend and an all-ones quotient
                    if (is_div) {hi, lo} <= opb == '0 ? {dvd, {W{1'b1}}} : {rem_s, quo_s};
                    else
`endif
                    if (!is_div) {hi, lo} <= (sa ^ sb) ? -acc : acc;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter; DIV expectations follow MDU_DIV_EN
module tb_mdu_iter;
    import mdu_pkg::*;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic clk = 0, reset = 1, start = 0, busy, done;
    logic [1:0] op = 0, mt_we = 0;
    logic [31:0] a = 0, b = 0, wd = 0, hi, lo;
    logic [31:0] mhi = 0, mlo = 0;
    typedef struct { logic [31:0] h; logic [31:0] l; int c; } exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0, cyc = 0, nbusy = 0;

    mdu_iter dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mt_we(mt_we), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (done) begin
        exp_t e;
        check("busy_with_done", 64'(busy), 64'd0);
        check("expect_pending", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("result_hi", 64'(hi), 64'(e.h));
            check("result_lo", 64'(lo), 64'(e.l));
            check("done_cycle", 64'(cyc), 64'(e.c));
        end
    end

    task automatic go(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] eh, input logic [31:0] el, input logic [1:0] mw, input bit poke);
        int lat = 33;
        if (o[1] && !DIV_EN) begin
            eh = mhi;
            el = mlo;
            lat = 1;
        end
        @(negedge clk);
        sbq.push_back('{eh, el, cyc + 1 + lat});
        start = 1; op = o; a = aa; b = bb; mt_we = mw; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 0; mt_we = 0; a = $urandom; b = $urandom;
        if (mw != 0) begin
            check("mt_with_start_hi", 64'(hi), 64'(mhi));
            check("mt_with_start_lo", 64'(lo), 64'(mlo));
        end
        nbusy = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy) nbusy++;
            if (poke && i == 5) begin start = 1; op = OP_DIVU; mt_we = 2'b11; wd = 32'h5555_AAAA; end
            if (poke && i == 6) begin start = 0; mt_we = 0; end
            if (poke && i == 8) begin
                check("hold_hi_busy", 64'(hi), 64'(mhi));
                check("hold_lo_busy", 64'(lo), 64'(mlo));
            end
            @(negedge clk);
        end
        check("done_seen", 64'(done), 64'd1);
        mhi = eh;
        mlo = el;
    endtask

    task automatic mt(input logic [1:0] mw, input logic [31:0] d);
        @(negedge clk);
        mt_we = mw; wd = d;
        @(negedge clk);
        mt_we = 0;
        if (mw[1]) mhi = d;
        if (mw[0]) mlo = d;
        check("mt_hi", 64'(hi), 64'(mhi));
        check("mt_lo", 64'(lo), 64'(mlo));
    endtask

    initial begin
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        go(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b00, 0);
        go(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2'b00, 0);
        check("mult_busy_cycles", 64'(nbusy), 64'd33);
        go(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'b00, 0);
        check("div_busy_cycles", 64'(nbusy), DIV_EN ? 64'd33 : 64'd1);
        go(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 2'b00, 0);
        go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 2'b00, 0);
        go(OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 2'b00, 0);
        go(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 2'b00, 0);
        go(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 2'b00, 0);
        go(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 2'b00, 0);
        go(OP_MULTU, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 2'b00, 1);
        check("poke_busy_cycles", 64'(nbusy), 64'd33);
        go(OP_MULT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0);
        mt(2'b10, 32'h1234_5678);
        mt(2'b11, 32'hCAFE_F00D);
        @(negedge clk);
        start = 1; op = DIV_EN ? OP_DIV : OP_MULT; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        #2 reset = 1;
        #1;
        check("midop_rst_busy", 64'(busy), 64'd0);
        check("midop_rst_done", 64'(done), 64'd0);
        check("midop_rst_hi", 64'(hi), 64'd0);
        check("midop_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 0;
        mhi = 0;
        mlo = 0;
        go(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 2'b00, 0);
        go(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 2'b00, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
